// File: rtl/liang_pkg.sv
// Shared core types and constants; the fetch stage adds its FSM states, reset PC and output bundle.
package liang_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [31:0] inst_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } ifu_state_e;

    localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;

    typedef struct packed {
        inst_t           inst;
        logic [XLEN-1:0] pc;
        logic            err;
    } ifu_out_t;

endpackage

// File: rtl/ifu_out_buf.sv
// One-entry output register toward decode: load sets valid, a consume or flush clears it.
module ifu_out_buf
    import liang_pkg::*;
#(
    parameter int unsigned DW = $bits(ifu_out_t)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic          flush_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] data_o
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (flush_i || (valid_q && ready_i)) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: single-outstanding imem requests, redirect handling, one-entry buffer to decode.
// Optional performance counters are compiled in when IFU_PERF_EN is defined.
//
// state | meaning
// BOOT  | idle cycle after reset, picks first fetch address
// REQ   | request valid on imem, held until accepted
// WAIT  | request accepted, waiting for its single response
// HOLD  | instruction buffered, waiting for decode to take it
module ifu_fetch
    import liang_pkg::*;
#(
    parameter int unsigned     XLEN     = liang_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = liang_pkg::RESET_PC
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    input  logic            imem_rsp_err_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic            fetch_err_o
`ifdef IFU_PERF_EN
    ,
    output logic [63:0]     perf_inst_cnt_o,
    output logic [63:0]     perf_stall_cnt_o
`endif
);

    typedef struct packed {
        inst_t           inst;
        logic [XLEN-1:0] pc;
        logic            err;
    } out_t;

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] target;
    logic            buf_load, buf_flush, buf_valid;
    out_t            buf_in, buf_out;

    assign target = redirect_pc_i & {{(XLEN-2){1'b1}}, 2'b00};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        addr_d           = addr_q;
        drop_d           = drop_q;
        buf_load         = 1'b0;
        buf_flush        = 1'b0;
        imem_req_valid_o = 1'b0;
        buf_in.inst      = imem_rsp_data_i;
        buf_in.pc        = addr_q;
        buf_in.err       = imem_rsp_err_i;

        if (redirect_valid_i) pc_d = target;

        case (state_q)
            BOOT: begin
                state_d = REQ;
                addr_d  = redirect_valid_i ? target : pc_q;
            end
            REQ: begin
                imem_req_valid_o = 1'b1;
                // The request can't be withdrawn, so a redirect only marks its response stale.
                if (redirect_valid_i) drop_d = 1'b1;
                if (imem_req_ready_i) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid_i) begin
                    if (!drop_q && !redirect_valid_i) begin
                        buf_load = 1'b1;
                        pc_d     = addr_q + XLEN'(4);
                        state_d  = HOLD;
                    end else begin
                        drop_d  = 1'b0;
                        addr_d  = redirect_valid_i ? target : pc_q;
                        state_d = REQ;
                    end
                end else if (redirect_valid_i) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid_i) begin
                    buf_flush = 1'b1;
                    addr_d    = target;
                    state_d   = REQ;
                end else if (inst_ready_i) begin
                    addr_d  = pc_q;
                    state_d = REQ;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    ifu_out_buf #(.DW($bits(out_t))) u_out_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (buf_load),
        .data_i  (buf_in),
        .flush_i (buf_flush),
        .valid_o (buf_valid),
        .ready_i (inst_ready_i),
        .data_o  (buf_out)
    );

    assign imem_req_addr_o = addr_q;
    assign inst_valid_o    = buf_valid;
    assign inst_o          = buf_out.inst;
    assign pc_o            = buf_out.pc;
    assign fetch_err_o     = buf_out.err;

`ifdef IFU_PERF_EN
    logic [63:0] inst_cnt_q, stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inst_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (buf_valid && inst_ready_i) inst_cnt_q <= inst_cnt_q + 64'd1;
            if (state_q == REQ || state_q == WAIT) stall_cnt_q <= stall_cnt_q + 64'd1;
        end
    end

    assign perf_inst_cnt_o  = inst_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a small imem model with programmable latency, checked step by step.
module tb_ifu_fetch;
    import liang_pkg::*;

    localparam logic [31:0] KEY = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, mem_ready;
    logic [31:0] req_addr;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, pc;
    logic        err;
`ifdef IFU_PERF_EN
    logic [63:0] perf_inst, perf_stall;
    int          hs_cnt;
`endif

    int          lat;
    int          cnt = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] err_addr;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .imem_req_valid_o (req_valid),
        .imem_req_ready_i (mem_ready),
        .imem_req_addr_o  (req_addr),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .imem_rsp_err_i   (rsp_err),
        .redirect_valid_i (redirect),
        .redirect_pc_i    (redirect_pc),
        .inst_valid_o     (inst_valid),
        .inst_ready_i     (inst_ready),
        .inst_o           (inst),
        .pc_o             (pc),
        .fetch_err_o      (err)
`ifdef IFU_PERF_EN
        ,
        .perf_inst_cnt_o  (perf_inst),
        .perf_stall_cnt_o (perf_stall)
`endif
    );

    // Memory keeps counting through reset so a late response can land in BOOT.
    always @(posedge clk) begin
        if (cnt != 0) cnt <= cnt - 1;
        if (req_valid && mem_ready) begin
            cnt       <= lat;
            pend_addr <= req_addr;
        end
    end

    assign rsp_valid = (cnt == 1);
    assign rsp_data  = pend_addr ^ KEY;
    assign rsp_err   = (pend_addr == err_addr);

`ifdef IFU_PERF_EN
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) hs_cnt <= 0;
        else if (inst_valid && inst_ready) hs_cnt <= hs_cnt + 1;
    end
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_req(input string tag, input logic [31:0] a);
        int n = 0;
        while (!req_valid && n < 30) begin
            step();
            n++;
        end
        check({tag, "_req_seen"}, 64'(req_valid), 64'd1);
        check({tag, "_req_addr"}, 64'(req_addr), 64'(a));
    endtask

    task automatic wait_inst(input string tag, input logic [31:0] a, input logic e);
        int n = 0;
        while (!inst_valid && n < 30) begin
            step();
            n++;
        end
        check({tag, "_inst_seen"}, 64'(inst_valid), 64'd1);
        check({tag, "_pc"}, 64'(pc), 64'(a));
        check({tag, "_inst"}, 64'(inst), 64'(a ^ KEY));
        check({tag, "_err"}, 64'(err), 64'(e));
    endtask

    initial begin
        mem_ready   = 1'b1;
        inst_ready  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        lat         = 1;
        err_addr    = 32'h8000_0008;

        step();
        step();
        check("rst_req_valid", 64'(req_valid), 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst", 64'(inst), 64'd0);
        check("rst_pc", 64'(pc), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst_n = 1'b1;
        check("boot_idle", 64'(req_valid), 64'd0);

        // Streaming: one instruction every 3 cycles
        step();
        check("s0_req_valid", 64'(req_valid), 64'd1);
        check("s0_req_addr", 64'(req_addr), 64'h8000_0000);
        step();
        check("s0_wait_req", 64'(req_valid), 64'd0);
        check("s0_wait_inst", 64'(inst_valid), 64'd0);
        step();
        check("s0_inst_valid", 64'(inst_valid), 64'd1);
        check("s0_pc", 64'(pc), 64'h8000_0000);
        check("s0_inst", 64'(inst), 64'(32'h8000_0000 ^ KEY));
        step();
        check("s1_req_addr", 64'(req_addr), 64'h8000_0004);
        check("s1_inst_cleared", 64'(inst_valid), 64'd0);
        step();
        step();
        check("s1_inst_valid", 64'(inst_valid), 64'd1);
        check("s1_pc", 64'(pc), 64'h8000_0004);
        step();
        check("s2_req_addr", 64'(req_addr), 64'h8000_0008);
        inst_ready = 1'b0;
        step();
        step();

        // Decode stalls 5 cycles on a faulted fetch
        for (int i = 0; i < 5; i++) begin
            check("stall_inst_valid", 64'(inst_valid), 64'd1);
            check("stall_pc", 64'(pc), 64'h8000_0008);
            check("stall_inst", 64'(inst), 64'(32'h8000_0008 ^ KEY));
            check("stall_err", 64'(err), 64'd1);
            check("stall_no_req", 64'(req_valid), 64'd0);
            step();
        end
        inst_ready = 1'b1;
        step();
        check("after_stall_req", 64'(req_addr), 64'h8000_000C);
        check("after_stall_inst", 64'(inst_valid), 64'd0);

        // Redirect while waiting on a slow response
        lat = 3;
        step();
        check("wait_state", 64'(req_valid), 64'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h8000_0103;
        step();
        redirect = 1'b0;
        lat      = 1;
        wait_req("redir_wait", 32'h8000_0100);
        check("redir_wait_no_inst", 64'(inst_valid), 64'd0);
        wait_inst("redir_wait", 32'h8000_0100, 1'b0);

        // Redirect while the request is back-pressured
        mem_ready = 1'b0;
        step();
        check("bp_req_addr", 64'(req_addr), 64'h8000_0104);
        redirect    = 1'b1;
        redirect_pc = 32'h8000_0200;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", 64'(req_valid), 64'd1);
            check("bp_hold_addr", 64'(req_addr), 64'h8000_0104);
            step();
        end
        mem_ready = 1'b1;
        step();
        wait_req("redir_req", 32'h8000_0200);
        wait_inst("redir_req", 32'h8000_0200, 1'b0);

        // Redirect in HOLD together with decode ready
        redirect    = 1'b1;
        redirect_pc = 32'h8000_0300;
        step();
        redirect = 1'b0;
        check("hold_redir_req", 64'(req_addr), 64'h8000_0300);
        check("hold_redir_valid", 64'(req_valid), 64'd1);
        check("hold_redir_inst", 64'(inst_valid), 64'd0);
        wait_inst("hold_redir", 32'h8000_0300, 1'b0);

        // Reset in the middle of WAIT; the late response lands during BOOT
        lat = 2;
        step();
        check("pre_rst_req", 64'(req_addr), 64'h8000_0304);
        step();
        check("pre_rst_wait", 64'(req_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_valid", 64'(req_valid), 64'd0);
        check("mid_rst_inst_valid", 64'(inst_valid), 64'd0);
        check("mid_rst_inst", 64'(inst), 64'd0);
        check("mid_rst_pc", 64'(pc), 64'd0);
        step();
        lat   = 1;
        rst_n = 1'b1;
        check("late_rsp_present", 64'(rsp_valid), 64'd1);
        step();
        check("post_rst_req_valid", 64'(req_valid), 64'd1);
        check("post_rst_req_addr", 64'(req_addr), 64'h8000_0000);
        check("post_rst_inst", 64'(inst_valid), 64'd0);
        wait_inst("post_rst", 32'h8000_0000, 1'b0);
        step();
`ifdef IFU_PERF_EN
        check("perf_inst_cnt", perf_inst, 64'(hs_cnt));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
